// File: rtl/flash_cmd_sequencer.sv
// Flash command sequencer: turns one host command into a fixed list of
// flash-controller bus steps (command writes, status reads, status polling),
// then reports completion with a one-cycle done pulse.
//
// Handshakes:
//   host side: a command is taken on a rising edge where cmd_valid && cmd_ready.
//     cmd_ready is high only in IDLE, so cmd_valid is ignored at other times.
//   bus side:  each step is one fc_read_op/fc_write_op pulse (ISSUE). The
//     controller then raises fc_stall (WAIT_BUSY) and drops it again
//     (WAIT_DONE); the step completes on the edge where fc_stall is seen low
//     in WAIT_DONE, and read data is sampled on that same edge.
module flash_cmd_sequencer #(
  parameter logic [23:0] POLL_LIMIT = 24'd8_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  output logic        done,
  output logic [7:0]  status,
  output logic        error,
  output logic        timeout,
  output logic [31:0] fc_addr,
  output logic        fc_read_op,
  output logic        fc_write_op,
  output logic [31:0] fc_data_write,
  input  logic [31:0] fc_data_read,
  input  logic        fc_stall,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    NEXT      = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [1:0] OP_PROG  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_RDST  = 2'b10;
  localparam logic [1:0] OP_RDARR = 2'b11;

  // Step index map shared by all commands:
  //   0,1 command-specific setup, 2 status poll, 3 clear-status (only on
  //   error), 4 back to read-array, 5 finished.
  localparam logic [2:0] IDX_FIRST = 3'd0;
  localparam logic [2:0] IDX_POLL  = 3'd2;
  localparam logic [2:0] IDX_CLEAR = 3'd3;
  localparam logic [2:0] IDX_FLUSH = 3'd4;
  localparam logic [2:0] IDX_END   = 3'd5;

  state_t      state;
  logic [1:0]  op_q;
  logic [15:0] data_q;
  logic [2:0]  step_idx;
  logic [23:0] poll_cnt;

  logic [2:0]  start_idx;
  logic [1:0]  iss_op;
  logic [2:0]  iss_idx;
  logic [15:0] iss_data;
  logic        iss_rd;
  logic [15:0] iss_val;

  logic [23:0] cnt_inc;
  logic [7:0]  rd_stat;
  logic [2:0]  cmp_idx;
  logic        cmp_err;
  logic        cmp_to;

  logic        unused_rd_hi;

  assign unused_rd_hi = ^fc_data_read[31:8];
  assign dbg_state    = state;

  function automatic logic step_is_read(input logic [1:0] op, input logic [2:0] idx);
    return (idx == IDX_POLL) || ((idx == 3'd1) && (op == OP_RDST));
  endfunction

  function automatic logic [15:0] step_value(input logic [1:0] op, input logic [2:0] idx,
                                             input logic [15:0] data);
    logic [15:0] v;
    case (idx)
      3'd0: begin
        case (op)
          OP_PROG:  v = 16'h0040;
          OP_ERASE: v = 16'h0020;
          default:  v = 16'h0070;
        endcase
      end
      3'd1:      v = (op == OP_PROG) ? data : 16'h00D0;
      IDX_CLEAR: v = 16'h0050;
      default:   v = 16'h00FF;
    endcase
    return v;
  endfunction

  // Select what the next ISSUE drives: live command inputs when starting, latched copy otherwise.
  always_comb begin
    start_idx = (cmd_op == OP_RDARR) ? IDX_FLUSH : IDX_FIRST;
    iss_op    = (state == IDLE) ? cmd_op    : op_q;
    iss_idx   = (state == IDLE) ? start_idx : step_idx;
    iss_data  = (state == IDLE) ? cmd_data  : data_q;
    iss_rd    = step_is_read(iss_op, iss_idx);
    iss_val   = step_value(iss_op, iss_idx, iss_data);
  end

  // Decide the step that follows the one completing now, including poll outcome.
  always_comb begin
    cnt_inc = (poll_cnt >= POLL_LIMIT) ? poll_cnt : poll_cnt + 24'd1;
    rd_stat = fc_data_read[7:0];
    cmp_idx = step_idx + 3'd1;
    cmp_err = error;
    cmp_to  = timeout;
    case (step_idx)
      3'd1: if (op_q == OP_RDST) cmp_idx = IDX_CLEAR;
      IDX_POLL: begin
        if (rd_stat[7]) begin
          cmp_err = |rd_stat[5:1];
          cmp_idx = IDX_CLEAR;
        end else if (cnt_inc >= POLL_LIMIT) begin
          cmp_err = 1'b1;
          cmp_to  = 1'b1;
          cmp_idx = IDX_CLEAR;
        end else begin
          cmp_idx = IDX_POLL;
        end
      end
      default: ;
    endcase
    // The clear-status write only happens when the command failed.
    if ((cmp_idx == IDX_CLEAR) && !cmp_err) cmp_idx = IDX_FLUSH;
  end

  // Main sequencer FSM with registered host and bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= 2'b00;
      data_q        <= 16'h0000;
      step_idx      <= 3'd0;
      poll_cnt      <= 24'd0;
      cmd_ready     <= 1'b1;
      done          <= 1'b0;
      status        <= 8'h00;
      error         <= 1'b0;
      timeout       <= 1'b0;
      fc_addr       <= 32'h0;
      fc_read_op    <= 1'b0;
      fc_write_op   <= 1'b0;
      fc_data_write <= 32'h0;
    end else begin
      done        <= 1'b0;
      fc_read_op  <= 1'b0;
      fc_write_op <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q        <= cmd_op;
            data_q      <= cmd_data;
            fc_addr     <= cmd_addr;
            step_idx    <= start_idx;
            poll_cnt    <= 24'd0;
            error       <= 1'b0;
            timeout     <= 1'b0;
            cmd_ready   <= 1'b0;
            fc_read_op  <= iss_rd;
            fc_write_op <= !iss_rd;
            if (!iss_rd) fc_data_write <= {16'h0000, iss_val};
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (fc_stall) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!fc_stall) begin
            if (step_is_read(op_q, step_idx)) status <= rd_stat;
            if (step_idx == IDX_POLL) poll_cnt <= cnt_inc;
            error    <= cmp_err;
            timeout  <= cmp_to;
            step_idx <= cmp_idx;
            if (cmp_idx == IDX_END) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          fc_read_op  <= iss_rd;
          fc_write_op <= !iss_rd;
          if (!iss_rd) fc_data_write <= {16'h0000, iss_val};
          state       <= ISSUE;
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Testbench for flash_cmd_sequencer: a reference model predicts the bus steps
// and final result of each command, a flash-controller responder answers the
// bus, and monitors compare everything the DUT presents against the queues.
module tb_flash_cmd_sequencer;

  localparam logic [23:0] LIMIT = 24'd4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        done;
  logic [7:0]  status;
  logic        error;
  logic        timeout;
  logic [31:0] fc_addr;
  logic        fc_read_op;
  logic        fc_write_op;
  logic [31:0] fc_data_write;
  logic [31:0] fc_data_read;
  logic        fc_stall;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  flash_cmd_sequencer #(.POLL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .done(done), .status(status), .error(error), .timeout(timeout),
    .fc_addr(fc_addr), .fc_read_op(fc_read_op), .fc_write_op(fc_write_op),
    .fc_data_write(fc_data_write), .fc_data_read(fc_data_read), .fc_stall(fc_stall),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [48:0] exp_q[$];       // bus steps: {is_read, addr, write value}
  logic [9:0]  exp_done_q[$];  // results: {status, error, timeout}
  logic [7:0]  resp_q[$];      // status bytes the responder returns on reads
  logic [7:0]  plan_q[$];      // status bytes the next command's reads will see
  logic [7:0]  model_status = 8'h00;
  int force_dly  = 0;
  int force_busy = 0;
  int rd_seen    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  // ---------------- reference model ----------------
  task automatic exp_write(input logic [31:0] a, input logic [15:0] v);
    exp_q.push_back({1'b0, a, v});
  endtask

  task automatic exp_read(input logic [31:0] a, output logic [7:0] st);
    st = (plan_q.size() != 0) ? plan_q.pop_front() : 8'h80;
    resp_q.push_back(st);
    exp_q.push_back({1'b1, a, 16'h0000});
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic [31:0] a, input logic [15:0] d);
    logic [7:0] st;
    logic [7:0] r;
    logic       err;
    logic       to;
    st  = model_status;
    err = 1'b0;
    to  = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        exp_write(a, (op == 2'b00) ? 16'h0040 : 16'h0020);
        exp_write(a, (op == 2'b00) ? d : 16'h00D0);
        for (int i = 1; i <= int'(LIMIT); i++) begin
          exp_read(a, r);
          st = r;
          if (r[7]) begin
            err = (r[5:1] != 5'd0);
            break;
          end
          if (i == int'(LIMIT)) begin
            err = 1'b1;
            to  = 1'b1;
          end
        end
      end
      2'b10: begin
        exp_write(a, 16'h0070);
        exp_read(a, r);
        st = r;
      end
      default: ;
    endcase
    if (err) exp_write(a, 16'h0050);
    exp_write(a, 16'h00FF);
    model_status = st;
    exp_done_q.push_back({st, err, to});
    plan_q.delete();
  endtask

  // ---------------- flash-controller responder ----------------
  logic [1:0]  phase;
  int          cnt;
  logic        cur_rd;
  logic [7:0]  cur_resp;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  // Answer each bus op with an optional idle gap, a stall window, then read data.
  always @(negedge clk) begin
    if (!rst_n) begin
      phase    = 2'd0;
      fc_stall = 1'b0;
    end else begin
      case (phase)
        2'd0: begin
          if (fc_read_op || fc_write_op) begin
            cur_rd    = fc_read_op;
            cur_addr  = fc_addr;
            cur_wdata = fc_data_write;
            cur_resp  = 8'h80;
            if (fc_read_op) begin
              rd_seen++;
              if (resp_q.size() != 0) cur_resp = resp_q.pop_front();
            end
            cnt = (force_dly != 0) ? force_dly : int'($urandom_range(0, 2));
            if (cnt == 0) begin
              fc_stall = 1'b1;
              cnt      = (force_busy != 0) ? force_busy : int'($urandom_range(2, 4));
              phase    = 2'd2;
            end else begin
              phase = 2'd1;
            end
          end
        end
        2'd1: begin
          cnt--;
          if (cnt == 0) begin
            fc_stall = 1'b1;
            cnt      = (force_busy != 0) ? force_busy : int'($urandom_range(2, 4));
            phase    = 2'd2;
          end
        end
        default: begin
          cnt--;
          if (cnt == 0) begin
            fc_stall          = 1'b0;
            fc_data_read      = $urandom();
            fc_data_read[7:0] = cur_resp;
            check("addr_hold", 64'(fc_addr), 64'(cur_addr));
            if (!cur_rd) check("wdata_hold", 64'(fc_data_write), 64'(cur_wdata));
            phase = 2'd0;
          end
        end
      endcase
    end
  end

  // ---------------- monitors ----------------
  // Compare every bus op pulse and every done pulse against the expected queues.
  always @(negedge clk) begin
    logic [48:0] e;
    logic [9:0]  x;
    if (rst_n) begin
      if (fc_read_op || fc_write_op) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_op: rd=%0b wr=%0b addr=0x%0h data=0x%0h, expected no op",
                   fc_read_op, fc_write_op, fc_addr, fc_data_write);
        end else begin
          e = exp_q.pop_front();
          check("op_exclusive", 64'(fc_read_op & fc_write_op), 64'd0);
          check("op_kind_is_read", 64'(fc_read_op), 64'(e[48]));
          check("op_addr", 64'(fc_addr), 64'(e[47:16]));
          if (!e[48]) check("op_wdata", 64'(fc_data_write), 64'({16'h0000, e[15:0]}));
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: status=0x%0h error=%0b timeout=%0b, expected no done",
                   status, error, timeout);
        end else begin
          x = exp_done_q.pop_front();
          check("done_status", 64'(status), 64'(x[9:2]));
          check("done_error", 64'(error), 64'(x[1]));
          check("done_timeout", 64'(timeout), 64'(x[0]));
          check("ready_low_with_done", 64'(cmd_ready), 64'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic [1:0] op, input logic [31:0] a, input logic [15:0] d);
    int guard;
    guard = 0;
    model_cmd(op, a, d);
    while (!cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) flag("ready_wait");
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom());
    cmd_addr  = $urandom();
    cmd_data  = 16'($urandom());
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!done && guard < 3000) begin
      @(negedge clk);
      guard++;
      cmd_valid = 1'b0;
      if (!done && !cmd_ready && $urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom());
        cmd_addr  = $urandom();
        cmd_data  = 16'($urandom());
      end
    end
    cmd_valid = 1'b0;
    if (!done) flag("done_wait");
    @(negedge clk);
    check("done_single_cycle", 64'(done), 64'd0);
    check("ready_after_done", 64'(cmd_ready), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_status"}, 64'(status), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_ops"}, 64'({fc_read_op, fc_write_op}), 64'd0);
    check({tag, "_fc_addr"}, 64'(fc_addr), 64'd0);
    check({tag, "_fc_wdata"}, 64'(fc_data_write), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          guard;
    int          base;
    logic [1:0]  op;
    logic [7:0]  r;
    cmd_valid    = 1'b0;
    cmd_op       = 2'b00;
    cmd_addr     = 32'h0;
    cmd_data     = 16'h0;
    fc_stall     = 1'b0;
    fc_data_read = 32'h0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // program, ready on third poll
    plan_q = '{8'h00, 8'h00, 8'h80};
    start_cmd(2'b00, 32'h0000_0100, 16'hBEEF);
    wait_done();
    // erase with device error bit
    plan_q = '{8'hA0};
    start_cmd(2'b01, 32'h0002_0000, 16'h1234);
    wait_done();
    // poll timeout
    plan_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    start_cmd(2'b00, 32'h0000_0300, 16'h5555);
    wait_done();
    // read status
    plan_q = '{8'h80};
    start_cmd(2'b10, 32'h0000_0400, 16'h0000);
    wait_done();
    // read-array: status must persist from the previous command
    start_cmd(2'b11, 32'h0000_0500, 16'hFFFF);
    wait_done();
    // slow controller: stall rises 3 cycles after each op
    force_dly = 3;
    plan_q = '{8'h00, 8'h80};
    start_cmd(2'b01, 32'h0004_0000, 16'h0000);
    wait_done();
    force_dly = 0;

    // randomized commands
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        r = 8'($urandom());
        if ($urandom_range(0, 9) < 4) begin
          r[7] = 1'b1;
          if ($urandom_range(0, 1) == 0) r = 8'h80;
        end else begin
          r[7] = 1'b0;
        end
        plan_q.push_back(r);
      end
      start_cmd(op, $urandom() & 32'hFFFF_FFFE, 16'($urandom()));
      wait_done();
    end

    // reset in the middle of a status poll
    force_busy = 6;
    plan_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    base = rd_seen;
    start_cmd(2'b00, 32'h0000_0600, 16'hAAAA);
    guard = 0;
    while (rd_seen == base && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (rd_seen == base) flag("poll_read_seen");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    exp_q.delete();
    resp_q.delete();
    exp_done_q.delete();
    model_status = 8'h00;
    force_busy   = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    start_cmd(2'b11, 32'h0000_0700, 16'h0000);
    wait_done();

    repeat (4) @(negedge clk);
    check("bus_queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
